// File: rtl/cpu_pkg.sv
// Shared CPU definitions: loader state encoding and instruction constants
// used by both the program loader and the halt decode.
package cpu_pkg;
    localparam int          INSTR_BYTES = 4;
    localparam logic [31:0] HALT_WORD   = 32'hFFFF_FFFF;

    typedef enum logic [3:0] {
        LD_IDLE,
        LD_LEN_LO,
        LD_LEN_HI,
        LD_DATA,
        LD_WRITE,
        LD_HALT_WR,
        LD_CHECK,
        LD_DONE,
        LD_ERROR
    } loader_state_t;
endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface program_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    // master: the loader (consumes bytes, drives memory writes)
    modport master (
        input  byte_valid, byte_data,
        output byte_ready, mem_we, mem_addr, mem_wdata
    );
    // slave: byte source / instruction memory side
    modport slave (
        output byte_valid, byte_data,
        input  byte_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/byte_assembler.sv
// Little-endian byte-to-word assembler: collects INSTR_BYTES bytes and flags
// the byte that completes a word, presenting the full word combinationally.
module byte_assembler
    import cpu_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic [31:0] word_nxt,
    output logic        word_valid
);
    logic [1:0]  cnt;
    logic [23:0] word_q;

    // Only the three earlier bytes need storage; the last one arrives live.
    assign word_nxt   = {byte_data, word_q};
    assign word_valid = byte_en && (cnt == 2'(INSTR_BYTES - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            word_q <= '0;
        end else if (clear) begin
            cnt    <= '0;
            word_q <= '0;
        end else if (byte_en) begin
            cnt    <= cnt + 2'd1;
            word_q <= {byte_data, word_q[23:8]};
        end
    end
endmodule

// File: rtl/program_loader.sv
// Streams a length-prefixed, XOR-checksummed program into instruction memory
// and holds the CPU in reset until the load verifies.
module program_loader
    import cpu_pkg::*;
#(
    parameter int          MAX_WORDS   = 256,
    parameter int          APPEND_HALT = 1,
    parameter logic [31:0] HALT_WORD   = cpu_pkg::HALT_WORD
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    start,
    program_loader_if.master        bus,
    output logic                    cpu_reset,
    output logic                    done,
    output logic                    error,
    output logic [15:0]             words_loaded
);
    // Largest legal word count leaves room for the halt word when appended.
    localparam logic [16:0] LEN_LIMIT =
        17'(MAX_WORDS - ((APPEND_HALT != 0) ? 1 : 0));

    loader_state_t state, state_nxt;
    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [7:0]  chk;
    logic        xfer, launch, asm_en, word_valid;
    logic [15:0] len_full;
    logic [31:0] word_nxt;

    assign xfer     = bus.byte_valid && bus.byte_ready;
    assign len_full = {bus.byte_data, len_lo};
    assign asm_en   = xfer && (state == LD_DATA);

    byte_assembler u_asm (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear      (launch),
        .byte_en    (asm_en),
        .byte_data  (bus.byte_data),
        .word_nxt   (word_nxt),
        .word_valid (word_valid)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= LD_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        unique case (state)
            LD_IDLE, LD_DONE, LD_ERROR: begin
                if (start) begin
                    state_nxt = LD_LEN_LO;
                    launch    = 1'b1;
                end
            end
            LD_LEN_LO: if (xfer) state_nxt = LD_LEN_HI;
            LD_LEN_HI: begin
                if (xfer) begin
                    if (len_full == 16'd0 || {1'b0, len_full} > LEN_LIMIT)
                        state_nxt = LD_ERROR;
                    else
                        state_nxt = LD_DATA;
                end
            end
            LD_DATA: if (word_valid) state_nxt = LD_WRITE;
            LD_WRITE: begin
                if (words_loaded + 16'd1 == len)
                    state_nxt = (APPEND_HALT != 0) ? LD_HALT_WR : LD_CHECK;
                else
                    state_nxt = LD_DATA;
            end
            LD_HALT_WR: state_nxt = LD_CHECK;
            LD_CHECK: begin
                if (xfer) state_nxt = (bus.byte_data == chk) ? LD_DONE : LD_ERROR;
            end
            default: state_nxt = LD_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they align with it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.byte_ready <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            cpu_reset      <= 1'b1;
            done           <= 1'b0;
            error          <= 1'b0;
            words_loaded   <= '0;
            len_lo         <= '0;
            len            <= '0;
            chk            <= '0;
        end else begin
            bus.byte_ready <= (state_nxt == LD_LEN_LO) || (state_nxt == LD_LEN_HI) ||
                              (state_nxt == LD_DATA)   || (state_nxt == LD_CHECK);
            bus.mem_we     <= (state_nxt == LD_WRITE) || (state_nxt == LD_HALT_WR);
            cpu_reset      <= (state_nxt != LD_DONE);
            done           <= (state_nxt == LD_DONE);
            error          <= (state_nxt == LD_ERROR);

            if (launch) begin
                chk          <= '0;
                words_loaded <= '0;
            end else if (xfer && state != LD_CHECK) begin
                chk <= chk ^ bus.byte_data;
            end

            if (xfer && state == LD_LEN_LO) len_lo <= bus.byte_data;
            if (xfer && state == LD_LEN_HI) len    <= len_full;

            if (state == LD_DATA && state_nxt == LD_WRITE) begin
                bus.mem_addr  <= {14'd0, words_loaded, 2'b00};
                bus.mem_wdata <= word_nxt;
            end
            if (state_nxt == LD_HALT_WR) begin
                bus.mem_addr  <= {14'd0, len, 2'b00};
                bus.mem_wdata <= HALT_WORD;
            end
            if (state == LD_WRITE) words_loaded <= words_loaded + 16'd1;
        end
    end
endmodule
